krake_edge_capture: RTL and testbench
=====================================

Name: krake_edge_capture

Overview:
- Input front-end for one Krake I/O port, sitting between the pad inputs and the port register block.
- Synchronises the 6 raw channel inputs and drives the synchronised value to the port block's ch_in.
- Detects masked rising and falling edges, and logs each event (pin snapshot plus 8-bit timestamp) into a small FIFO.
- The FIFO is read over the same 8-bit strobe/ack register bus used by the port block.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..16.
PRESCALE, 1, clk_i cycles per timestamp tick; 1..256.

Ports:
clk_i  in  1  system clock; all logic on posedge.
rst_i  in  1  reset, asynchronous, active-high.
stb_i  in  1  bus access strobe.
we_i  in  1  1 = write, 0 = read.
adr_i  in  4  register address.
dat_i  in  8  write data.
dat_o  out  8  read data; valid while ack_o = 1.
ack_o  out  1  access acknowledge.
ch_raw  in  6  asynchronous pad inputs.
ch_sync  out  6  synchronised inputs, to the port block's ch_in.
irq_o  out  1  capture interrupt, level.

Behaviour:
- Reset values (asynchronous): ack_o=0, dat_o=0, ch_sync=0, irq_o=0, all sync/edge flops=0, CTRL=0, masks=0, FIFO empty, overflow=0, timestamp=0, prescaler=0.
- Synchroniser:
  - Two flops; ch_sync is the second stage. A raw change appears on ch_sync 2 cycles later.
  - A third flop holds prev.
  - rise = ch_sync & ~prev; fall = ~ch_sync & prev.
- Registers:
  - 0x0 CTRL (R/W): bit0 EN. bit1 CLR is write-only and self-clearing; it empties the FIFO and clears overflow. Reads return {7'b0, EN}.
  - 0x1 RISE_MASK (R/W): bits 5:0.
  - 0x2 FALL_MASK (R/W): bits 5:0.
  - 0x3 STATUS (R): bit0 empty, bit1 full, bit2 overflow, bits 7:3 count (0..DEPTH). Writing 1 to bit2 clears overflow; other bits are ignored.
  - 0x4 DATA_LO (R): {2'b0, snapshot} of the head entry, no pop. Returns 0 when empty.
  - 0x5 DATA_HI (R): timestamp of the head entry, and pops the head. Returns 0 and does not pop when empty.
  - Other addresses: reads return 0 and writes are ignored; they are still acked.
- Handshake:
  - An access is accepted on any posedge where stb_i=1 and ack_o=0.
  - ack_o=1 for exactly the next cycle, with dat_o valid in that same cycle. Read latency is 1 cycle.
  - While ack_o=1, stb_i is ignored. A held strobe therefore yields one access every 2 cycles.
  - dat_o=0 whenever ack_o=0.
  - Register writes and pops take effect at the accepting edge.
- Timestamp:
  - 8-bit counter, advances 1 every PRESCALE cycles while EN=1, wraps 255->0.
  - A write that sets EN from 0 to 1 clears both the counter and the prescaler.
  - The counter freezes while EN=0.
- Capture:
  - Event when EN=1 and ((rise & RISE_MASK) | (fall & FALL_MASK)) != 0.
  - On an event, push {ch_sync, timestamp} on the same edge as the ch_sync update's successor cycle. Total: raw edge to count increment = 3 cycles.
  - Push while full: entry dropped, overflow set (sticky).
  - Simultaneous push and pop when not full: both performed, count unchanged.
  - Simultaneous push and pop when full: pop first, push accepted, no overflow.
  - Simultaneous CLR and push: CLR wins, FIFO left empty.
  - Simultaneous overflow-set and W1C: set wins.
- Pointers wrap modulo DEPTH; count saturates at DEPTH only through the full check.
- irq_o is registered: irq_o = (EN & ~empty) | overflow, updated one cycle after state changes.
- Reset mid-operation: everything returns immediately to reset values; an in-flight ack is dropped.

Test Plan:
- Reset/readback: write RISE_MASK=0x3F and CTRL=0x01, read both -> 0x3F and 0x01. Assert rst_i mid-access -> ack_o=0, STATUS reads 0x01.
- Single edge: PRESCALE=1, EN=1, RISE_MASK=0x01, ch_raw 0->0x01 at cycle t:
  - ch_sync=0x01 at t+2, count=1 at t+3.
  - DATA_LO returns 0x01; DATA_HI returns the timestamp, then STATUS returns 0x01 (empty).
- Mask filtering: FALL_MASK=0x04, RISE_MASK=0. Toggle ch0 high, then low -> no entries. Drop ch2 -> 1 entry with snapshot bit2=0.
- Overflow: DEPTH=16, 17 masked edges with no reads:
  - STATUS=0x86 (count 16, full, overflow) and irq_o=1.
  - Write STATUS 0x04 -> overflow=0; 16 pops return the original order.
- Full with simultaneous pop: FIFO full, pop coinciding with an event -> count stays 16, overflow stays 0, newest entry appears at the tail.
- Bus edges:
  - Held stb_i for 6 cycles on DATA_HI with 4 entries -> 3 acks, 3 pops, count=1.
  - Read of 0xF -> ack with 0x00.
  - DATA_HI read when empty -> 0x00, count remains 0.

Source files
------------

// File: rtl/krake_edge_capture.sv
`timescale 1ns/1ps
// Pad-input front end: 2-flop sync, masked edge capture into a timestamped FIFO, 8-bit strobe/ack bus.
// Bus reads return one cycle after accept; a held strobe is served every other cycle; events arriving while full are dropped.
module krake_edge_capture #(
    parameter int DEPTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [3:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    input  logic [5:0] ch_raw,
    output logic [5:0] ch_sync,
    output logic       irq_o
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [7:0] PS_MAX  = 8'(PRESCALE - 1);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [5:0]    sync_q1, prev;
    logic          en, ovf;
    logic [5:0]    rise_mask, fall_mask;
    logic [7:0]    ts, pre;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    cnt;
    logic [13:0]   mem [DEPTH];

    logic       accept, wr, rd, empty, full, evt, clr, pop, push, ovf_set, ovf_w1c, en_start;
    logic [5:0] rise, fall;
    logic [13:0] head;
    logic [7:0] rd_data;
    logic       unused_dat;

    assign unused_dat = &{1'b0, dat_i[7:6]};

    assign accept   = stb_i & ~ack_o;
    assign wr       = accept & we_i;
    assign rd       = accept & ~we_i;
    assign empty    = (cnt == 5'd0);
    assign full     = (cnt == DEPTH_C);
    assign rise     = ch_sync & ~prev;
    assign fall     = ~ch_sync & prev;
    assign evt      = en & (|((rise & rise_mask) | (fall & fall_mask)));
    assign clr      = wr && (adr_i == 4'h0) && dat_i[1];
    assign en_start = wr && (adr_i == 4'h0) && dat_i[0] && !en;
    assign pop      = rd && (adr_i == 4'h5) && !empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push     = evt && (!full || pop);
    assign ovf_set  = evt && full && !pop;
    assign ovf_w1c  = wr && (adr_i == 4'h3) && dat_i[2];
    assign head     = mem[rd_ptr];

    always_comb begin
        rd_data = 8'h00;
        case (adr_i)
            4'h0: rd_data = {7'b0, en};
            4'h1: rd_data = {2'b0, rise_mask};
            4'h2: rd_data = {2'b0, fall_mask};
            4'h3: rd_data = {cnt, ovf, full, empty};
            4'h4: rd_data = empty ? 8'h00 : {2'b0, head[13:8]};
            4'h5: rd_data = empty ? 8'h00 : head[7:0];
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {ch_sync, ts};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o     <= 1'b0;
            dat_o     <= 8'h00;
            sync_q1   <= 6'h00;
            ch_sync   <= 6'h00;
            prev      <= 6'h00;
            en        <= 1'b0;
            rise_mask <= 6'h00;
            fall_mask <= 6'h00;
            ts        <= 8'h00;
            pre       <= 8'h00;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= 5'd0;
            ovf       <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            ack_o   <= accept;
            dat_o   <= rd ? rd_data : 8'h00;
            sync_q1 <= ch_raw;
            ch_sync <= sync_q1;
            prev    <= ch_sync;

            if (wr) begin
                case (adr_i)
                    4'h0: en        <= dat_i[0];
                    4'h1: rise_mask <= dat_i[5:0];
                    4'h2: fall_mask <= dat_i[5:0];
                    default: ;
                endcase
            end

            if (en_start) begin
                ts  <= 8'h00;
                pre <= 8'h00;
            end else if (en) begin
                if (pre == PS_MAX) begin
                    pre <= 8'h00;
                    ts  <= ts + 8'h01;
                end else begin
                    pre <= pre + 8'h01;
                end
            end

            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= 5'd0;
                ovf    <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   cnt <= cnt + 5'd1;
                    2'b01:   cnt <= cnt - 5'd1;
                    default: cnt <= cnt;
                endcase
                ovf <= ovf_set | (ovf & ~ovf_w1c);
            end

            irq_o <= (en & ~empty) | ovf;
        end
    end
endmodule

// File: tb/tb_krake_edge_capture.sv
`timescale 1ns/1ps
// Directed bench for krake_edge_capture; bus reads are scored by a negedge monitor against a queue of expected values.
module tb_krake_edge_capture;
    logic       clk_i = 1'b0;
    logic       rst_i, stb_i, we_i;
    logic [3:0] adr_i;
    logic [7:0] dat_i;
    logic [7:0] dat_o;
    logic       ack_o;
    logic [5:0] ch_raw;
    logic [5:0] ch_sync;
    logic       irq_o;

    krake_edge_capture #(.DEPTH(16), .PRESCALE(1)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stb_i   (stb_i),
        .we_i    (we_i),
        .adr_i   (adr_i),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .ack_o   (ack_o),
        .ch_raw  (ch_raw),
        .ch_sync (ch_sync),
        .irq_o   (irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         is_read;
        logic [7:0] exp;
        int         id;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rd_id = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, req);
        end
    endtask

    // Every ack consumes one queue entry; only reads carry a checked value.
    always @(negedge clk_i) begin
        exp_t e;
        if (ack_o === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack with dat_o=0x%02h, expected no ack", dat_o);
            end else begin
                e = sbq.pop_front();
                if (e.is_read) check($sformatf("read_%0d", e.id), dat_o, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [7:0] e, input bit chk = 1'b1);
        exp_t x;
        x.is_read = chk;
        x.exp     = e;
        x.id      = rd_id++;
        sbq.push_back(x);
        stb_i = 1'b1; we_i = 1'b0; adr_i = a;
        tick();
        stb_i = 1'b0;
        tick();
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        exp_t x;
        x.is_read = 1'b0;
        x.exp     = 8'h00;
        x.id      = -1;
        sbq.push_back(x);
        stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d;
        tick();
        stb_i = 1'b0; we_i = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n_ack;
        rst_i = 1'b1; stb_i = 1'b0; we_i = 1'b0; adr_i = 4'h0; dat_i = 8'h00; ch_raw = 6'h00;
        repeat (3) tick();
        check("rst_ack", {7'b0, ack_o}, 8'h00);
        check("rst_dat", dat_o, 8'h00);
        check("rst_sync", {2'b0, ch_sync}, 8'h00);
        check("rst_irq", {7'b0, irq_o}, 8'h00);
        rst_i = 1'b0;
        tick();
        bus_read(4'h3, 8'h01);
        bus_read(4'h0, 8'h00);

        // Readback, then reset while an ack is in flight
        bus_write(4'h1, 8'h3F);
        bus_write(4'h0, 8'h01);
        bus_read(4'h1, 8'h3F);
        bus_read(4'h0, 8'h01);
        stb_i = 1'b1; we_i = 1'b0; adr_i = 4'h3;
        tick();
        check("pre_rst_ack", {7'b0, ack_o}, 8'h01);
        rst_i = 1'b1; stb_i = 1'b0;
        #1;
        check("mid_rst_ack", {7'b0, ack_o}, 8'h00);
        tick();
        rst_i = 1'b0;
        tick();
        bus_read(4'h3, 8'h01);
        bus_read(4'h0, 8'h00);

        // Single rising edge, timestamp restarted by the EN write
        bus_write(4'h1, 8'h01);
        bus_write(4'h0, 8'h01);
        ch_raw = 6'h01;
        tick();
        check("sync_t1", {2'b0, ch_sync}, 8'h00);
        tick();
        check("sync_t2", {2'b0, ch_sync}, 8'h01);
        bus_read(4'h3, 8'h01);
        bus_read(4'h3, 8'h08);
        check("irq_single", {7'b0, irq_o}, 8'h01);
        bus_read(4'h4, 8'h01);
        bus_read(4'h5, 8'h03);
        bus_read(4'h3, 8'h01);

        // Mask filtering: only the ch2 fall is logged
        bus_write(4'h1, 8'h00);
        bus_write(4'h2, 8'h04);
        ch_raw = 6'h00; repeat (4) tick();
        ch_raw = 6'h01; repeat (4) tick();
        ch_raw = 6'h05; repeat (4) tick();
        bus_read(4'h3, 8'h01);
        ch_raw = 6'h01; repeat (4) tick();
        bus_read(4'h3, 8'h08);
        bus_read(4'h4, 8'h01);
        bus_write(4'h0, 8'h03);
        bus_read(4'h3, 8'h01);

        // Overflow: 17 edges, snapshots 0x02..0x12, last one dropped
        bus_write(4'h1, 8'h3F);
        bus_write(4'h2, 8'h3F);
        for (int k = 0; k < 17; k++) begin
            ch_raw = 6'(k + 2);
            tick(); tick();
        end
        repeat (4) tick();
        bus_read(4'h3, 8'h86);
        check("irq_ovf", {7'b0, irq_o}, 8'h01);
        bus_write(4'h3, 8'h04);
        bus_read(4'h3, 8'h82);

        // Pop lands on the same edge as a push into a full FIFO
        ch_raw = 6'h20;
        tick(); tick();
        bus_read(4'h5, 8'h00, 1'b0);
        bus_read(4'h3, 8'h82);
        for (int k = 1; k < 16; k++) begin
            bus_read(4'h4, 8'(k + 2));
            bus_read(4'h5, 8'h00, 1'b0);
        end
        bus_read(4'h4, 8'h20);
        bus_read(4'h5, 8'h00, 1'b0);
        bus_read(4'h3, 8'h01);

        // Four entries at timestamps 3, 7, 11, 15
        bus_write(4'h0, 8'h00);
        bus_write(4'h0, 8'h01);
        for (int k = 0; k < 4; k++) begin
            ch_raw = 6'(8'h21 + k);
            repeat (4) tick();
        end
        bus_read(4'h3, 8'h20);

        // Held strobe on DATA_HI for 6 cycles
        for (int k = 0; k < 3; k++) begin
            exp_t x;
            x.is_read = 1'b1;
            x.exp     = 8'(3 + 4 * k);
            x.id      = rd_id++;
            sbq.push_back(x);
        end
        n_ack = 0;
        stb_i = 1'b1; we_i = 1'b0; adr_i = 4'h5;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ack_o) n_ack++;
        end
        stb_i = 1'b0;
        tick();
        check("held_acks", 8'(n_ack), 8'h03);
        bus_read(4'h3, 8'h08);
        bus_read(4'h4, 8'h24);
        bus_read(4'h5, 8'h0F);
        bus_read(4'h3, 8'h01);
        bus_read(4'h5, 8'h00);
        bus_read(4'h3, 8'h01);
        bus_read(4'hF, 8'h00);
        check("irq_idle", {7'b0, irq_o}, 8'h00);

        repeat (3) tick();
        check("sb_drained", 8'(sbq.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
